// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//   Collects two consecutive words from a shared upstream bus into a
//   registered A/B operand pair for a downstream bitwise AND stage. The pair is
//   held until the consumer acknowledges it. Words that arrive while a full
//   pair is held are dropped and flagged.
//
// Ports
//   clk        : clock, all state updates on rising edge
//   reset      : asynchronous, active-low reset
//   Data_In    : shared operand word (N_BITS), qualified by Data_Valid
//   Data_Valid : Data_In qualifier
//   Consume    : downstream acknowledge of the held pair (only honoured in FULL)
//   Clear      : synchronous flush of pair and Overrun; highest priority
//   A, B       : registered operands (N_BITS)
//   Ready      : a complete pair is held (state FULL)
//   Expect_B   : the next accepted word goes to B (state WAIT_B)
//   Overrun    : sticky dropped-word flag
//   Pair_Count : pairs consumed, modulo 256
// -----------------------------------------------------------------------------
module operand_loader #(
    parameter int N_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] Data_In,
    input  logic              Data_Valid,
    input  logic              Consume,
    input  logic              Clear,
    output logic [N_BITS-1:0] A,
    output logic [N_BITS-1:0] B,
    output logic              Ready,
    output logic              Expect_B,
    output logic              Overrun,
    output logic [7:0]        Pair_Count
);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        FULL   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [N_BITS-1:0] a_q, a_d;
    logic [N_BITS-1:0] b_q, b_d;
    logic              ovr_q, ovr_d;
    logic [7:0]        cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            ovr_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;
        if (Clear) begin
            // Flush wins over everything; the consumed-pair count survives.
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (Data_Valid) begin
                        a_d     = Data_In;
                        state_d = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (Data_Valid) begin
                        b_d     = Data_In;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (Consume) begin
                        cnt_d = cnt_q + 8'd1;
                        // A word arriving with the acknowledge starts the next pair.
                        if (Data_Valid) begin
                            a_d     = Data_In;
                            state_d = WAIT_B;
                        end else begin
                            state_d = WAIT_A;
                        end
                    end else if (Data_Valid) begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign Ready      = (state_q == FULL);
    assign Expect_B   = (state_q == WAIT_B);
    assign Overrun    = ovr_q;
    assign Pair_Count = cnt_q;

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The module SHALL have parameter N_BITS, default 8, which sets the width of the data input and both operand outputs.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port Data_In, input, N_BITS: shared operand word from upstream.
REQ-005 The module SHALL have port Data_Valid, input, 1 bit: Data_In qualifier, sampled each rising edge.
REQ-006 The module SHALL have port Consume, input, 1 bit: downstream acknowledge that the current A/B pair has been used.
REQ-007 The module SHALL have port Clear, input, 1 bit: synchronous flush of the pair in progress and error flag.
REQ-008 The module SHALL have port A, output, N_BITS: registered first operand, fed to the downstream AND gate A input.
REQ-009 The module SHALL have port B, output, N_BITS: registered second operand, fed to the downstream AND gate B input.
REQ-010 The module SHALL have port Ready, output, 1 bit: high while a complete A/B pair is held.
REQ-011 The module SHALL have port Expect_B, output, 1 bit: high while the next accepted word goes to B.
REQ-012 The module SHALL have port Overrun, output, 1 bit: sticky flag set when a word is dropped.
REQ-013 The module SHALL have port Pair_Count, output, 8 bits: number of pairs consumed, modulo 256.

Function
REQ-014 The module SHALL implement a three-state FSM with states WAIT_A, WAIT_B and FULL, and all outputs SHALL be registered or decoded from registered state only.
REQ-015 In WAIT_A, when Data_Valid=1 the module SHALL load A<=Data_In and move to WAIT_B on the same edge.
REQ-016 In WAIT_B, when Data_Valid=1 the module SHALL load B<=Data_In and move to FULL.
REQ-017 Ready SHALL be 1 exactly when the state is FULL, and SHALL assert on the cycle after the B word is sampled (one-cycle latency from the second Data_Valid).
REQ-018 Expect_B SHALL be 1 exactly when the state is WAIT_B.
REQ-019 In FULL, A and B SHALL remain stable until Consume=1 is sampled.
REQ-020 In FULL, when Consume=1 and Data_Valid=0, the module SHALL return to WAIT_A and increment Pair_Count by 1.
REQ-021 In FULL, when Consume=1 and Data_Valid=1 in the same cycle, the module SHALL increment Pair_Count, load A<=Data_In and move directly to WAIT_B (no word lost).
REQ-022 In FULL, when Data_Valid=1 and Consume=0, the module SHALL drop the word, leave A, B and the state unchanged, and set Overrun=1.
REQ-023 Consume sampled in WAIT_A or WAIT_B SHALL be ignored: no state change and no count change.
REQ-024 Pair_Count SHALL wrap from 255 to 0 with no flag.
REQ-025 Overrun, once set, SHALL stay 1 until reset or Clear.
REQ-026 Clear=1 SHALL have priority over all other inputs: on that edge the state goes to WAIT_A, A and B go to 0, and Overrun goes to 0. Pair_Count SHALL be unchanged, and Data_Valid and Consume in that cycle SHALL be ignored.
REQ-027 Data_In SHALL be ignored whenever Data_Valid=0.

Reset
REQ-028 While reset=0, the module SHALL immediately, without waiting for a clock edge, force state=WAIT_A, A=0, B=0, Ready=0, Expect_B=0, Overrun=0 and Pair_Count=0.
REQ-029 Reset asserted mid-pair (in WAIT_B or FULL) SHALL discard the partial or complete pair, and no count increment SHALL occur.
REQ-030 After reset deassertion, the first Data_Valid sampled SHALL load A.

Verification
REQ-031 The bench SHALL cover basic load: Data_Valid with 0xF0, then Data_Valid with 0x3C, leading to A=0xF0, B=0x3C, Ready=1 one cycle after the second word, and downstream C=0x30.
REQ-032 The bench SHALL cover consume: in FULL, a Consume pulse leads to Ready=0 next cycle, state WAIT_A, and Pair_Count 0 to 1.
REQ-033 The bench SHALL cover simultaneous events: in FULL, Consume=1 and Data_Valid=1 with 0xAA leads to A=0xAA, Expect_B=1, Ready=0, and Pair_Count incremented.
REQ-034 The bench SHALL cover overrun: in FULL, Data_Valid with 0x55 and no Consume leads to A/B unchanged and Overrun=1. A following Clear leads to Overrun=0, A=B=0, and WAIT_A.
REQ-035 The bench SHALL cover wrap: 256 load/consume cycles lead to Pair_Count returning to 0.
REQ-036 The bench SHALL cover asynchronous reset: reset=0 asserted mid-cycle in WAIT_B leads to all outputs 0 before the next clk edge. After release, 0x0F loads into A.
